// File: rtl/guess_arbiter_if.sv
// Bundle of guess-arbiter handshake signals between the player receive buffers,
// the game core and the arbiter; master drives the inputs, slave is the arbiter.
interface guess_arbiter_if;
    logic       p0_ready;
    logic [7:0] p0_byte;
    logic       p1_ready;
    logic [7:0] p1_byte;
    logic       game_rdy;
    logic       new_round;
    logic [7:0] guess;
    logic       guess_valid;
    logic       guess_player;
    logic       turn;
    logic       dup_err;
    logic       inv_err;
    logic       timeout;

    modport master (
        output p0_ready, p0_byte, p1_ready, p1_byte, game_rdy, new_round,
        input  guess, guess_valid, guess_player, turn, dup_err, inv_err, timeout
    );

    modport slave (
        input  p0_ready, p0_byte, p1_ready, p1_byte, game_rdy, new_round,
        output guess, guess_valid, guess_player, turn, dup_err, inv_err, timeout
    );
endinterface

// File: rtl/guess_arbiter.sv
// Turn-based arbiter feeding validated, uppercase, non-repeated guesses from two players
// to the game core. Define GUESS_ARB_TIMEOUT_EN to forfeit idle turns after TIMEOUT_CYCLES.
module guess_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic           clk,
    input  logic           nRst,
    guess_arbiter_if.slave arb
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_OFFER = 2'd2;

    if (TIMEOUT_CYCLES < 1 || (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
        $error("guess_arbiter: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    function automatic logic [7:0] fold_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A);
    endfunction

    logic [1:0]  r_state;
    logic        r_turn;
    logic [25:0] r_used;
    logic        r_pflag0;
    logic        r_pflag1;
    logic [7:0]  r_pend0;
    logic [7:0]  r_pend1;
    logic [7:0]  r_work;
    logic [7:0]  r_guess;
    logic        r_guess_valid;
    logic        r_guess_player;
    logic        r_dup_err;
    logic        r_inv_err;

    logic        w_take0;
    logic        w_take1;
    logic        w_take;
    logic [7:0]  w_letter;
    logic        w_is_letter;
    logic [4:0]  w_idx;
    logic [25:0] w_mask;
    logic        w_dup;
    logic        w_to_hit;

    assign w_take0     = (r_state == S_WAIT) && !r_turn && r_pflag0;
    assign w_take1     = (r_state == S_WAIT) &&  r_turn && r_pflag1;
    assign w_take      = w_take0 || w_take1;
    assign w_letter    = fold_upper(r_work);
    assign w_is_letter = is_upper(w_letter);
    assign w_idx       = 5'(w_letter - 8'h41);
    assign w_mask      = w_is_letter ? (26'd1 << w_idx) : 26'd0;
    assign w_dup       = |(r_used & w_mask);

    // A fresh strobe beats a same-edge consume, so the newest byte always survives.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pflag0 <= 1'b0;
            r_pflag1 <= 1'b0;
        end else if (arb.new_round) begin
            r_pflag0 <= 1'b0;
            r_pflag1 <= 1'b0;
        end else begin
            if (arb.p0_ready)  r_pflag0 <= 1'b1;
            else if (w_take0)  r_pflag0 <= 1'b0;
            if (arb.p1_ready)  r_pflag1 <= 1'b1;
            else if (w_take1)  r_pflag1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (arb.p0_ready) r_pend0 <= arb.p0_byte;
        if (arb.p1_ready) r_pend1 <= arb.p1_byte;
        if (w_take)       r_work  <= r_turn ? r_pend1 : r_pend0;
    end

`ifdef GUESS_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // A pending guess from the turn player wins over an expiring counter.
    assign w_to_hit = (r_state == S_WAIT) && !w_take && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (arb.new_round) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (r_state == S_WAIT && !w_take && !w_to_hit) r_cnt <= r_cnt + 1'b1;
            else                                           r_cnt <= '0;
        end
    end

    assign arb.timeout = r_timeout;
`else
    assign w_to_hit    = 1'b0;
    assign arb.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state        <= S_WAIT;
            r_turn         <= 1'b0;
            r_used         <= '0;
            r_guess        <= 8'h00;
            r_guess_valid  <= 1'b0;
            r_guess_player <= 1'b0;
            r_dup_err      <= 1'b0;
            r_inv_err      <= 1'b0;
        end else begin
            r_dup_err <= 1'b0;
            r_inv_err <= 1'b0;
            if (arb.new_round) begin
                r_state       <= S_WAIT;
                r_turn        <= 1'b0;
                r_used        <= '0;
                r_guess_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (w_take)        r_state <= S_CHECK;
                        else if (w_to_hit) r_turn  <= ~r_turn;
                    end
                    S_CHECK: begin
                        if (!w_is_letter) begin
                            r_inv_err <= 1'b1;
                            r_state   <= S_WAIT;
                        end else if (w_dup) begin
                            r_dup_err <= 1'b1;
                            r_state   <= S_WAIT;
                        end else begin
                            r_used         <= r_used | w_mask;
                            r_guess        <= w_letter;
                            r_guess_player <= r_turn;
                            r_guess_valid  <= 1'b1;
                            r_state        <= S_OFFER;
                        end
                    end
                    S_OFFER: begin
                        if (arb.game_rdy) begin
                            r_guess_valid <= 1'b0;
                            r_turn        <= ~r_turn;
                            r_state       <= S_WAIT;
                        end
                    end
                    default: r_state <= S_WAIT;
                endcase
            end
        end
    end

    assign arb.guess        = r_guess;
    assign arb.guess_valid  = r_guess_valid;
    assign arb.guess_player = r_guess_player;
    assign arb.turn         = r_turn;
    assign arb.dup_err      = r_dup_err;
    assign arb.inv_err      = r_inv_err;

endmodule

// File: doc/guess_arbiter.md
Name: guess_arbiter

Overview:
- Turn-based scheduler sharing the single game-core guess input between two player receive channels (P0, P1).
- Holds a one-deep pending byte per player and validates it: letter only, uppercase-folded, not already guessed this round.
- Offers the validated guess to the game core with a valid/ready handshake, then hands the turn to the other player.
- Sits between the per-player UART receive buffers and the hangman game core.

Parameters:
- TIMEOUT_CYCLES, 1000: WAIT cycles allowed before the current turn is forfeited (used only with the optional feature).
- CNT_W, 16: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- p0_ready  in  1  one-cycle strobe, p0_byte valid
- p0_byte  in  8  P0 received ASCII byte
- p1_ready  in  1  one-cycle strobe, p1_byte valid
- p1_byte  in  8  P1 received ASCII byte
- game_rdy  in  1  game core accepts guess this cycle
- new_round  in  1  one-cycle strobe: clear history, turn to P0
- guess  out  8  uppercase ASCII guess offered to game core
- guess_valid  out  1  guess is valid; held until game_rdy
- guess_player  out  1  player owning the offered guess
- turn  out  1  player whose turn it is
- dup_err  out  1  one-cycle pulse: letter already used
- inv_err  out  1  one-cycle pulse: byte not A-Z/a-z
- timeout  out  1  one-cycle pulse: turn forfeited

Behaviour:
- Reset (nRst=0, asynchronous): state=WAIT, turn=0, used mask=0, both pending flags=0, timeout counter=0. Outputs: guess=8'h00, guess_valid=0, guess_player=0, dup_err=0, inv_err=0, timeout=0.
- Capture, any state: px_ready=1 loads px_byte into pend_x and sets pend_flag_x on the same edge.
  - A byte arriving while pend_flag_x=1 overwrites the held byte (newest wins).
  - Capture and consume on the same edge: the flag stays set and holds the new byte.
- State WAIT:
  - If pend_flag[turn]=1: latch the pending byte into the working register, clear pend_flag[turn], go to CHECK.
  - The other player's pending byte is kept, not consumed.
- State CHECK (exactly 1 cycle):
  - Fold a-z to A-Z (byte minus 8'h20).
  - Not a letter: inv_err=1 for one cycle; return to WAIT; turn unchanged.
  - Letter whose used[letter-'A'] bit is set: dup_err=1 for one cycle; return to WAIT; turn unchanged.
  - Otherwise: set the used bit, load guess and guess_player=turn, go to OFFER.
- State OFFER:
  - guess_valid=1; guess and guess_player held stable.
  - On the edge where game_rdy=1: guess_valid=0, turn flips, go to WAIT; guess keeps its last value.
  - game_rdy while not in OFFER is ignored.
- Latency: p_ready of the turn player sampled at edge N while idle in WAIT gives CHECK at edge N+1 and guess_valid=1 after edge N+2. Minimum throughput is one guess per 3 cycles plus game-core stall.
- new_round:
  - Highest priority below reset, in any state: next edge mask=0, pend flags=0, turn=0, state=WAIT, guess_valid=0, counter=0. Any offer in flight is aborted.
  - A px_ready on the same edge is discarded.
- Used mask is 26 bits, index letter-'A'. Persists across turns, cleared only by reset or new_round.
- Error and timeout pulses last exactly one cycle and are mutually exclusive.

Optional Feature:
- Macro GUESS_ARB_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle in WAIT while pend_flag[turn]=0.
  - On reaching TIMEOUT_CYCLES-1: timeout=1 for one cycle, turn flips, counter=0.
  - The counter clears on leaving WAIT, on a turn flip and on new_round.
  - The turn-player pending check has priority over timeout on the same edge.
- Undefined: no counter logic; timeout tied 0; a turn waits indefinitely.

Test Plan:
- Reset mid-OFFER (P0 'E' offered, nRst pulsed low) -> guess_valid=0 and turn=0 asynchronously; after release, a new 'E' from P0 is accepted, not dup_err.
- P0 sends 8'h61 ('a'), game_rdy=1 -> guess=8'h41 with guess_valid=1 two edges after capture edge; turn becomes 1 after accept.
- P1 sends 'A' after P0's accepted 'A' -> dup_err single pulse, no guess_valid, turn stays 1; P1 then sends 'B' -> guess=8'h42, guess_player=1.
- P0 sends 8'h35 ('5') on its turn -> inv_err pulse, turn stays 0; P1 sends 'C' during P0's turn -> held, offered only after P0 completes a valid guess.
- game_rdy held low 20 cycles in OFFER with 'D' -> guess_valid and guess stable all 20 cycles; new_round mid-OFFER -> guess_valid=0 next edge, turn=0, 'D' reusable.
- GUESS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no input -> timeout pulse after 8 WAIT cycles, turn 0->1; repeat -> 1->0; undefined build -> timeout never asserts.
